// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg
// Shared constants for the CP0 interrupt controller:
//   - register select codes used by the mtc0/mfc0 paths
//   - bit-field offsets inside SR and Cause
//   - the exception code reported for interrupts
//   - the request/acknowledge FSM state type
// ---------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register selects
    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_SR      = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;
    localparam logic [4:0] SEL_PRID    = 5'd15;
    localparam logic [4:0] SEL_INTCFG  = 5'd22;

    // Field offsets
    localparam int IM_LSB  = 16;   // SR.IM and Cause.IP share this offset
    localparam int ID_LSB  = 8;    // Cause.id
    localparam int EXC_LSB = 2;    // Cause.ExcCode
    localparam int SR_EXL  = 1;
    localparam int SR_IE   = 0;

    localparam logic [4:0] EXC_INT = 5'd0;

    // Request/acknowledge handshake with the CPU control FSM
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } cp0_state_t;

endpackage

// File: rtl/cp0_intc_irq_line.sv
// ---------------------------------------------------------------------------
// cp0_irq_line
// One external interrupt line: SYNC_STAGES-deep synchroniser, one
// edge-history flop, and the pending bit in either level or sticky-edge
// mode.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   irq_in      asynchronous interrupt source
//   edge_mode   1 = sticky edge-triggered, 0 = level-following
//   w1c         software write-1-to-clear for this pending bit
//   pending     pending (IP) bit for this line
// ---------------------------------------------------------------------------
module cp0_irq_line #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic w1c,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   pending_reg;
    logic                   sync_level;
    logic                   rise;

    assign sync_level = sync_reg[SYNC_STAGES-1];
    assign rise       = sync_level & ~hist_reg;
    assign pending    = pending_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0] <= irq_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg    <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            hist_reg <= sync_level;
            if (edge_mode) begin
                // A new edge outranks a same-cycle clear so no event is lost
                if (rise) begin
                    pending_reg <= 1'b1;
                end else if (w1c) begin
                    pending_reg <= 1'b0;
                end
            end else begin
                pending_reg <= sync_level;
            end
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// ---------------------------------------------------------------------------
// cp0_intc
// CP0 interrupt controller: NUM_IRQ synchronised hardware lines plus a
// Count/Compare timer (line 0), SR/Cause/EPC/PRID/IntCfg registers, a
// highest-index priority encoder and a request/acknowledge handshake with
// the multicycle CPU control FSM.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   din        mtc0 write data
//   pc         return address captured into EPC on acknowledge
//   hw_int     asynchronous interrupt sources (line i+1 = hw_int[i])
//   sel        CP0 register select
//   cp0_wr     write strobe for the selected register
//   int_ack    CPU accepts the pending interrupt
//   eret       return from handler
//   epc        EPC register
//   dout       mfc0 read data (combinational from sel)
//   int_req    interrupt request to the CPU
//   int_id     line index taken, latched at acknowledge
// ---------------------------------------------------------------------------
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ     = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID_VALUE  = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        din,
    input  logic [31:0]        pc,
    input  logic [NUM_IRQ-1:0] hw_int,
    input  logic [4:0]         sel,
    input  logic               cp0_wr,
    input  logic               int_ack,
    input  logic               eret,
    output logic [31:0]        epc,
    output logic [31:0]        dout,
    output logic               int_req,
    output logic [4:0]         int_id
);

    localparam int L = NUM_IRQ + 1;

    logic [31:0]  count_reg;
    logic [31:0]  compare_reg;
    logic [31:0]  epc_reg;
    logic [31:0]  prid_reg;
    logic [L-1:0] im_reg;
    logic         exl_reg;
    logic         ie_reg;
    logic         timer_ip_reg;
    logic [4:0]   cause_id_reg;
    logic [4:0]   int_id_reg;
    logic [L-1:0] intcfg_reg;

    cp0_state_t   state_reg;
    cp0_state_t   state_next;

    logic         wr_count;
    logic         wr_compare;
    logic         wr_sr;
    logic         wr_cause;
    logic         wr_intcfg;
    logic [L-1:0] w1c_bits;

    logic [NUM_IRQ-1:0] line_ip;
    logic [L-1:0]       ip;
    logic [L-1:0]       active;
    logic [4:0]         winner;
    logic               req_cond;
    logic               timer_match;
    logic               ack_take;
    logic               eret_take;
    logic               sr_exl_set;
    logic               sr_exl_clear;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_count     = cp0_wr && (sel == SEL_COUNT);
    assign wr_compare   = cp0_wr && (sel == SEL_COMPARE);
    assign wr_sr        = cp0_wr && (sel == SEL_SR);
    assign wr_cause     = cp0_wr && (sel == SEL_CAUSE);
    assign wr_intcfg    = cp0_wr && (sel == SEL_INTCFG);
    assign w1c_bits     = wr_cause ? din[IM_LSB +: L] : '0;
    assign sr_exl_set   = wr_sr && din[SR_EXL];
    assign sr_exl_clear = wr_sr && !din[SR_EXL];

    // ------------------------------------------------------------------
    // External lines
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            cp0_irq_line #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_line (
                .clk       (clk),
                .rst       (rst),
                .irq_in    (hw_int[gi]),
                .edge_mode (intcfg_reg[gi+1]),
                .w1c       (w1c_bits[gi+1]),
                .pending   (line_ip[gi])
            );
        end
    endgenerate

    assign ip     = {line_ip, timer_ip_reg};
    assign active = ip & im_reg;

    // Highest set index wins: later iterations overwrite earlier ones
    always_comb begin
        winner = '0;
        for (int i = 0; i < L; i++) begin
            if (active[i]) begin
                winner = 5'(i);
            end
        end
    end

    assign req_cond = ie_reg && !exl_reg && (|active);

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    assign timer_match = (count_reg == compare_reg) && (compare_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            compare_reg  <= '0;
            timer_ip_reg <= 1'b0;
        end else begin
            count_reg <= wr_count ? din : count_reg + 32'd1;
            if (wr_compare) begin
                compare_reg <= din;
            end
            // Compare write acknowledges the timer and beats a same-cycle match
            if (wr_compare) begin
                timer_ip_reg <= 1'b0;
            end else if (timer_match) begin
                timer_ip_reg <= 1'b1;
            end else if (w1c_bits[0]) begin
                timer_ip_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ack_take   = 1'b0;
        eret_take  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (sr_exl_set) begin
                    state_next = ST_HANDLER;
                end else if (req_cond) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_HANDLER;
                end else if (sr_exl_set) begin
                    state_next = ST_HANDLER;
                end else if (!req_cond) begin
                    state_next = ST_RUN;
                end
            end
            ST_HANDLER: begin
                if (eret) begin
                    eret_take  = 1'b1;
                    state_next = ST_RUN;
                end else if (sr_exl_clear) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // SR, Cause.id, EPC, IntCfg, int_id
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_reg       <= '0;
            ie_reg       <= 1'b0;
            exl_reg      <= 1'b0;
            epc_reg      <= '0;
            cause_id_reg <= '0;
            int_id_reg   <= '0;
            intcfg_reg   <= '0;
            prid_reg     <= PRID_VALUE;
        end else begin
            if (wr_sr) begin
                im_reg <= din[IM_LSB +: L];
                ie_reg <= din[SR_IE];
            end
            // Acknowledge forces EXL even against a same-cycle SR write
            if (ack_take) begin
                exl_reg <= 1'b1;
            end else if (eret_take) begin
                exl_reg <= 1'b0;
            end else if (wr_sr) begin
                exl_reg <= din[SR_EXL];
            end
            if (ack_take) begin
                epc_reg      <= pc;
                cause_id_reg <= winner;
                int_id_reg   <= winner;
            end
            if (wr_intcfg) begin
                // Timer line is always sticky, so its mode bit stays 0
                intcfg_reg <= {din[L-1:1], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign epc     = epc_reg;
    assign int_req = (state_reg == ST_REQ);
    assign int_id  = int_id_reg;

    always_comb begin
        dout = '0;
        case (sel)
            SEL_COUNT:   dout = count_reg;
            SEL_COMPARE: dout = compare_reg;
            SEL_SR: begin
                dout[IM_LSB +: L] = im_reg;
                dout[SR_EXL]      = exl_reg;
                dout[SR_IE]       = ie_reg;
            end
            SEL_CAUSE: begin
                dout[IM_LSB +: L]  = ip;
                dout[ID_LSB +: 5]  = cause_id_reg;
                dout[EXC_LSB +: 5] = EXC_INT;
            end
            SEL_EPC:     dout = epc_reg;
            SEL_PRID:    dout = prid_reg;
            SEL_INTCFG:  dout[L-1:0] = intcfg_reg;
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// ---------------------------------------------------------------------------
// tb_cp0_intc
// Directed bench for cp0_intc with NUM_IRQ = 6 (L = 7), SYNC_STAGES = 2.
// Inputs change on the falling edge; outputs are compared on the falling
// edge (or 1 ns after it for reads through sel).
// ---------------------------------------------------------------------------
module tb_cp0_intc;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [31:0] pc;
    logic [5:0]  hw_int;
    logic [4:0]  sel;
    logic        cp0_wr;
    logic        int_ack;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] dout;
    logic        int_req;
    logic [4:0]  int_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_intc #(
        .NUM_IRQ     (6),
        .SYNC_STAGES (2),
        .PRID_VALUE  (32'h0000_0001)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .pc      (pc),
        .hw_int  (hw_int),
        .sel     (sel),
        .cp0_wr  (cp0_wr),
        .int_ack (int_ack),
        .eret    (eret),
        .epc     (epc),
        .dout    (dout),
        .int_req (int_req),
        .int_id  (int_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] s, input logic [31:0] exp);
        sel = s;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic wr(input logic [4:0] s, input logic [31:0] d);
        @(negedge clk);
        sel    = s;
        din    = d;
        cp0_wr = 1'b1;
        @(negedge clk);
        cp0_wr = 1'b0;
        $display("wr  sel=%0d din=%08h", s, d);
    endtask

    task automatic do_ack(input logic [31:0] p);
        @(negedge clk);
        pc      = p;
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        $display("ack pc=%08h int_id=%0d epc=%08h", p, int_id, epc);
    endtask

    task automatic do_eret();
        @(negedge clk);
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        $display("eret");
    endtask

    initial begin
        rst     = 1'b1;
        din     = '0;
        pc      = '0;
        hw_int  = '0;
        sel     = '0;
        cp0_wr  = 1'b0;
        int_ack = 1'b0;
        eret    = 1'b0;

        // 1. Reset values (read while reset is held)
        @(negedge clk);
        chk_rd("rst_count",   SEL_COUNT,   32'h0);
        chk_rd("rst_compare", SEL_COMPARE, 32'h0);
        chk_rd("rst_sr",      SEL_SR,      32'h0);
        chk_rd("rst_cause",   SEL_CAUSE,   32'h0);
        chk_rd("rst_epc",     SEL_EPC,     32'h0);
        chk_rd("rst_prid",    SEL_PRID,    32'h0000_0001);
        chk_rd("rst_intcfg",  SEL_INTCFG,  32'h0);
        chk_rd("rst_unmapped", 5'd5,       32'h0);
        chk("rst_int_req", {31'd0, int_req}, 32'h0);
        chk("rst_int_id",  {27'd0, int_id},  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 2. Level line 2, latency, ack, eret, re-request
        wr(SEL_SR, 32'h0004_0001);
        hw_int[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_req_early", {31'd0, int_req}, 32'h0);
        @(negedge clk);
        chk("t2_req_lat4", {31'd0, int_req}, 32'h1);
        do_ack(32'h0040_0010);
        chk("t2_epc",     epc, 32'h0040_0010);
        chk("t2_int_id",  {27'd0, int_id}, 32'd2);
        chk("t2_req_off", {31'd0, int_req}, 32'h0);
        chk_rd("t2_sr_exl", SEL_SR,    32'h0004_0003);
        chk_rd("t2_cause",  SEL_CAUSE, 32'h0004_0200);
        do_eret();
        chk("t2_eret_run", {31'd0, int_req}, 32'h0);
        chk_rd("t2_sr_eret", SEL_SR, 32'h0004_0001);
        @(negedge clk);
        chk("t2_rereq", {31'd0, int_req}, 32'h1);
        hw_int[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_drop_early", {31'd0, int_req}, 32'h1);
        @(negedge clk);
        chk("t2_drop", {31'd0, int_req}, 32'h0);

        // 3. Edge mode on line 3, W1C, set beats same-cycle W1C
        wr(SEL_INTCFG, 32'h0000_0009);
        chk_rd("t3_intcfg", SEL_INTCFG, 32'h0000_0008);
        wr(SEL_SR, 32'h0008_0000);
        @(negedge clk);
        hw_int[2] = 1'b1;
        @(negedge clk);
        hw_int[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk_rd("t3_ip_set", SEL_CAUSE, 32'h0008_0200);
        repeat (3) @(negedge clk);
        chk_rd("t3_ip_sticky", SEL_CAUSE, 32'h0008_0200);
        wr(SEL_CAUSE, 32'h0008_0000);
        chk_rd("t3_w1c", SEL_CAUSE, 32'h0000_0200);
        @(negedge clk);
        hw_int[2] = 1'b1;
        @(negedge clk);
        hw_int[2] = 1'b0;
        @(negedge clk);
        sel    = SEL_CAUSE;
        din    = 32'h0008_0000;
        cp0_wr = 1'b1;
        @(negedge clk);
        cp0_wr = 1'b0;
        $display("wr  sel=%0d din=%08h (same-cycle edge)", SEL_CAUSE, 32'h0008_0000);
        chk_rd("t3_set_wins", SEL_CAUSE, 32'h0008_0200);
        wr(SEL_CAUSE, 32'h0008_0000);
        chk_rd("t3_w1c2", SEL_CAUSE, 32'h0000_0200);
        wr(SEL_INTCFG, 32'h0);

        // 4. Priority among lines 1, 4, 6
        wr(SEL_SR, 32'h0052_0000);
        hw_int = 6'b10_1001;
        repeat (4) @(negedge clk);
        chk_rd("t4_cause_ip", SEL_CAUSE, 32'h0052_0200);
        wr(SEL_SR, 32'h0052_0001);
        @(negedge clk);
        chk("t4_req", {31'd0, int_req}, 32'h1);
        do_ack(32'h0040_0100);
        chk("t4_id6", {27'd0, int_id}, 32'd6);
        chk_rd("t4_cause_id6", SEL_CAUSE, 32'h0052_0600);
        wr(SEL_SR, 32'h0012_0003);
        chk("t4_hdl_noreq", {31'd0, int_req}, 32'h0);
        do_eret();
        @(negedge clk);
        chk("t4_rereq", {31'd0, int_req}, 32'h1);
        do_ack(32'h0040_0200);
        chk("t4_id4", {27'd0, int_id}, 32'd4);
        chk("t4_epc", epc, 32'h0040_0200);
        hw_int = '0;
        do_eret();
        wr(SEL_SR, 32'h0);
        repeat (4) @(negedge clk);

        // 5. Count/Compare timer
        wr(SEL_SR, 32'h0001_0001);
        wr(SEL_COMPARE, 32'd10);
        wr(SEL_COUNT, 32'd0);
        chk_rd("t5_count0", SEL_COUNT, 32'd0);
        repeat (10) @(negedge clk);
        chk_rd("t5_count10", SEL_COUNT, 32'd10);
        chk_rd("t5_ip0_clr", SEL_CAUSE, 32'h0000_0400);
        @(negedge clk);
        chk_rd("t5_ip0_set", SEL_CAUSE, 32'h0001_0400);
        chk("t5_req_early", {31'd0, int_req}, 32'h0);
        @(negedge clk);
        chk("t5_req", {31'd0, int_req}, 32'h1);
        wr(SEL_COMPARE, 32'd10);
        chk_rd("t5_cmp_clear", SEL_CAUSE, 32'h0000_0400);
        @(negedge clk);
        chk("t5_req_drop", {31'd0, int_req}, 32'h0);
        wr(SEL_COUNT, 32'hFFFF_FFFF);
        chk_rd("t5_count_max", SEL_COUNT, 32'hFFFF_FFFF);
        @(negedge clk);
        chk_rd("t5_count_wrap", SEL_COUNT, 32'h0);
        wr(SEL_SR, 32'h0);

        // 6. Reset in REQ and in HANDLER
        wr(SEL_SR, 32'h0004_0001);
        hw_int[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_in_req", {31'd0, int_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_req_rst_req", {31'd0, int_req}, 32'h0);
        chk("t6_req_rst_id",  {27'd0, int_id},  32'h0);
        chk("t6_req_rst_epc", epc, 32'h0);
        chk_rd("t6_req_rst_sr", SEL_SR, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        sel    = SEL_SR;
        din    = 32'h0004_0001;
        cp0_wr = 1'b1;
        @(negedge clk);
        cp0_wr = 1'b0;
        $display("wr  sel=%0d din=%08h (after reset)", SEL_SR, 32'h0004_0001);
        repeat (2) @(negedge clk);
        chk("t6_rereq_early", {31'd0, int_req}, 32'h0);
        @(negedge clk);
        chk("t6_rereq", {31'd0, int_req}, 32'h1);
        do_ack(32'h0040_0300);
        chk("t6_hdl_id",  {27'd0, int_id}, 32'd2);
        chk("t6_hdl_epc", epc, 32'h0040_0300);
        #1 rst = 1'b1;
        #1;
        chk("t6_hdl_rst_epc", epc, 32'h0);
        chk("t6_hdl_rst_id",  {27'd0, int_id},  32'h0);
        chk("t6_hdl_rst_req", {31'd0, int_req}, 32'h0);
        chk_rd("t6_hdl_rst_sr",    SEL_SR,    32'h0);
        chk_rd("t6_hdl_rst_cause", SEL_CAUSE, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        hw_int = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised successor to the team's single-mask CP0 interrupt logic.
- Provides N synchronised hardware interrupt lines with per-line edge/level mode, sticky write-1-to-clear pending bits, a Count/Compare timer interrupt and a highest-index priority encoder.
- Adds an explicit request/acknowledge handshake with the multicycle CPU control FSM.
- Sits beside the register file; the CPU reads and writes it through sel-addressed mtc0/mfc0 paths.

Parameters:
- NUM_IRQ, 6: number of external interrupt lines (1..15). Total lines L = NUM_IRQ+1; line 0 is the timer, lines 1..NUM_IRQ are hw_int[0..NUM_IRQ-1].
- SYNC_STAGES, 2: flip-flop synchroniser depth per external line (>=1).
- PRID_VALUE, 32'h0000_0001: reset and read-only value of PRID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  32  write data from the register file.
- pc  in  32  return address captured into EPC on acknowledge.
- hw_int  in  NUM_IRQ  asynchronous interrupt sources.
- sel  in  5  CP0 register select.
- cp0_wr  in  1  write strobe for the sel register.
- int_ack  in  1  CPU accepts the interrupt at an instruction boundary.
- eret  in  1  return from handler.
- epc  out  32  EPC register.
- dout  out  32  read data for sel.
- int_req  out  1  interrupt request to the CPU.
- int_id  out  5  line index of the interrupt taken, latched at ack.

Behaviour:
- Register map by sel; unmapped sel reads 0 and ignores writes.
  - 9 Count: R/W.
  - 11 Compare: R/W.
  - 12 SR: IM at [16+L-1:16], EXL at [1], IE at [0]; other bits read 0.
  - 13 Cause: IP at [16+L-1:16], id at [12:8], ExcCode at [6:2] (always 0 = Int); W1C on IP bits.
  - 14 EPC: read-only to software.
  - 15 PRID: read-only.
  - 22 IntCfg: [L-1:0] mode per line, 1 = edge, 0 = level; bit 0 is ignored because the timer is always sticky.
- Reset values:
  - All registers 0, except PRID = PRID_VALUE.
  - Synchronisers cleared; state RUN.
  - int_req = 0, int_id = 0, epc = 0.
- Synchronisation: each hw_int bit passes through SYNC_STAGES flops, then one edge-history flop.
- Level line: IP bit follows the synchronised level each cycle and ignores W1C.
- Edge line:
  - IP bit sets on a synchronised 0->1 transition and stays set until software writes 1 to it in Cause.
  - If a set and a W1C land in the same cycle, the set wins.
- Timer:
  - Count increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - A software write to Count loads din in place of the increment.
  - When Count == Compare and Compare != 0, IP[0] sets (sticky).
  - Any Compare write clears IP[0]; the write takes precedence over a same-cycle match.
- Active set A = IP & IM. Priority: the highest set index in A wins.
- FSM states, one-hot or encoded:
  - RUN: go to REQ when IE & ~EXL & |A.
  - REQ: int_req = 1. Return to RUN if the condition drops (mask/IE write, or a level line deasserts). On int_ack: EPC <= pc, EXL <= 1, Cause.id and int_id <= priority winner of the same cycle, then go to HANDLER.
  - HANDLER: int_req = 0. eret sets EXL <= 0 and returns to RUN. A software write of SR.EXL = 0 has the same effect.
- int_ack outside REQ and eret outside HANDLER are ignored.
- Same-cycle events:
  - cp0_wr to SR together with int_ack: IM and IE take din; EXL is forced to 1 by the ack.
  - A write setting EXL = 1 while in RUN or REQ moves the state to HANDLER without touching EPC.
- Latency: external line edge to int_req = SYNC_STAGES+2 cycles, with IE = 1, EXL = 0 and the line unmasked. int_req is registered-state driven and glitch-free.
- Reset mid-handshake: everything returns to reset values immediately and asynchronously.
- dout is combinational from sel.

Decomposition:
- Package cp0_pkg holds:
  - sel constants (SEL_COUNT, SEL_COMPARE, SEL_SR, SEL_CAUSE, SEL_EPC, SEL_PRID, SEL_INTCFG);
  - bit-field offsets (IM_LSB = 16, ID_LSB = 8, EXC_LSB = 2);
  - EXC_INT = 0;
  - the FSM state enum.
- Sub-module cp0_irq_line, instantiated NUM_IRQ times: synchroniser, edge detect, sticky/level pending bit, W1C input.

Test Plan:
1. Reset, then read every sel. Expect PRID = 0x00000001, all others 0, int_req = 0.
2. SR = 0x0004_0001 (IM line 2), IntCfg = 0 (level), hw_int[1] = 1. Expect int_req high 4 cycles later. Ack with pc = 0x0040_0010: EPC = 0x0040_0010, SR.EXL = 1, int_id = 2, int_req = 0. eret: EXL = 0; int_req re-asserts because the level is still high.
3. Edge mode on line 3, hw_int[2] pulsed for 1 cycle. IP[3] stays set after the pulse. W1C 0x0008_0000 to Cause clears it. A pulse arriving in the same cycle as the W1C leaves IP[3] = 1.
4. Lines 1, 4, 6 all pending and unmasked. Expect the ack to latch int_id = 6. Masking line 6 in the handler, then eret and re-ack, gives int_id = 4.
5. Compare = 10, Count = 0, SR IM bit 16, IE = 1. Expect IP[0] set once Count reaches 10, then int_req. A Compare write clears IP[0]. Count = 0xFFFF_FFFF wraps to 0.
6. Assert rst while in REQ, and again while in HANDLER. All outputs 0, EPC = 0, state RUN; a line held high re-requests after the synchroniser latency.
